alu_datapath: RTL and testbench

//  Register/arithmetic datapath driven by the one-hot control word c[14:0] from the ALU control unit.

---
 rtl/alu_datapath.sv | 160 ++++++++++++++++
 tb/tb_alu_datapath.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_datapath.sv
// alu_datapath: accumulator/quotient/multiplicand register datapath for the
// sequential ALU. The one-hot control word c sequences add/sub, Booth radix-2
// signed multiply and non-restoring divide. The datapath returns q_0, q_min1,
// sign and cnt7 to the control unit and holds a registered 2*WIDTH result.
module alu_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     inbus_x,
  input  logic [WIDTH-1:0]     inbus_y,
  input  logic [14:0]          c,
  output logic                 q_0,
  output logic                 q_min1,
  output logic                 sign,
  output logic                 cnt7,
  output logic [2*WIDTH-1:0]   result,
  output logic                 overflow
);

  localparam int AW = WIDTH + 1;

  // Architectural registers
  logic [AW-1:0]     a;      // accumulator, one guard bit above WIDTH
  logic [WIDTH-1:0]  q;      // multiplier / dividend / quotient
  logic [WIDTH-1:0]  m;      // multiplicand / divisor / second operand
  logic              q_m1;   // Booth extra bit q(-1)
  logic [CNT_W-1:0]  cnt;    // iteration counter

  // Adder path shared by c4 (add or subtract) and c11 (restore)
  logic [AW-1:0]     m_ext;
  logic [AW-1:0]     addend;
  logic [AW-1:0]     a_sum;
  logic [AW-1:0]     a_restore;
  logic              ovf_next;

  // Decoded control groups
  logic init_any;
  logic init_load_x;

  assign init_load_x = c[1] | c[2];
  assign init_any    = c[0] | init_load_x;

  // Sign-extend M, pick add or two's-complement subtract, and form the
  // WIDTH-bit signed overflow of the low part of A combined with M.
  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    m_ext     = {m[WIDTH-1], m};
    addend    = m_ext;
    ovf_next  = 1'b0;
    if (c[5]) begin
      addend = ~m_ext + AW'(1);
    end
    a_sum     = a + addend;
    a_restore = a + m_ext;
    // Overflow: operands of equal effective sign yield a result of the other
    // sign. For subtract the effective sign of M is inverted.
    if (c[5]) begin
      ovf_next = (a[WIDTH-1] != m[WIDTH-1]) && (a_sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      ovf_next = (a[WIDTH-1] == m[WIDTH-1]) && (a_sum[WIDTH-1] != a[WIDTH-1]);
    end
  end

  // Accumulator A: init > c4 > c8 > c9 > c11
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so that every
    // register in this design samples the pre-edge values of the others.
    if (rst) begin
      a <= '0;
    end else if (c[0]) begin
      a <= {inbus_x[WIDTH-1], inbus_x};
    end else if (init_load_x) begin
      a <= '0;
    end else if (c[4]) begin
      a <= a_sum;
    end else if (c[8]) begin
      a <= {a[AW-1], a[AW-1:1]};
    end else if (c[9]) begin
      a <= {a[WIDTH-1:0], q[WIDTH-1]};
    end else if (c[11]) begin
      a <= a_restore;
    end
  end

  // Q register: init > c8 > c9 > c6
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (c[0]) begin
      q <= '0;
    end else if (init_load_x) begin
      q <= inbus_x;
    end else if (c[8]) begin
      q <= {a[0], q[WIDTH-1:1]};
    end else if (c[9]) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end else if (c[6]) begin
      q <= {q[WIDTH-1:1], ~a[AW-1]};
    end
  end

  // Booth bit q(-1): cleared on init, captures Q[0] on the right shift
  always_ff @(posedge clk) begin
    if (rst || init_any) begin
      q_m1 <= 1'b0;
    end else if (c[8]) begin
      q_m1 <= q[0];
    end
  end

  // Operand M loads from Y on c3
  always_ff @(posedge clk) begin
    if (rst) begin
      m <= '0;
    end else if (c[3]) begin
      m <= inbus_y;
    end
  end

  // Iteration counter: cleared on init, natural wrap on c7/c10
  always_ff @(posedge clk) begin
    if (rst || init_any) begin
      cnt <= '0;
    end else if (c[7] || c[10]) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Overflow flag tracks only the most recent c4 operation
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (c[4]) begin
      overflow <= ovf_next;
    end
  end

  // Result register: c13 > c12 > c14; c14 keeps the remainder half
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (c[13]) begin
      result <= {a[WIDTH-1:0], q};
    end else if (c[12]) begin
      result <= {{WIDTH{1'b0}}, a[WIDTH-1:0]};
    end else if (c[14]) begin
      result <= {q, result[WIDTH-1:0]};
    end
  end

  // Status back to the control unit, straight from registers
  assign q_0    = q[0];
  assign q_min1 = q_m1;
  assign sign   = a[AW-1];
  assign cnt7   = (cnt == {CNT_W{1'b1}});

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: drives alu_datapath with the control sequences a control
// unit would issue and compares against plain-arithmetic expectations.
module tb_alu_datapath;

  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    inbus_x;
  logic [W-1:0]    inbus_y;
  logic [14:0]     c;
  logic            q_0;
  logic            q_min1;
  logic            sign;
  logic            cnt7;
  logic [2*W-1:0]  result;
  logic            overflow;

  int n_checks = 0;
  int n_errors = 0;

  alu_datapath #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .inbus_x  (inbus_x),
    .inbus_y  (inbus_y),
    .c        (c),
    .q_0      (q_0),
    .q_min1   (q_min1),
    .sign     (sign),
    .cnt7     (cnt7),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] cb(input int n);
    logic [14:0] v;
    v    = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with control word cw; outputs settle 1ns after the edge
  task automatic cycle(input logic [14:0] cw);
    c = cw;
    @(posedge clk);
    #1;
    c = '0;
  endtask

  task automatic do_addsub(input logic [W-1:0] x, input logic [W-1:0] y,
                           input bit sub, input bit chk_status);
    int sx, sy, r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = sub ? sx - sy : sx + sy;
    inbus_x = x;
    inbus_y = y;
    cycle(cb(0));
    cycle(cb(3));
    cycle(cb(4) | (sub ? cb(5) : 15'd0));
    if (chk_status) check("as_sign", 32'(sign), 32'(r < 0));
    check("as_ovf", 32'(overflow), 32'(r > 127 || r < -128));
    cycle(cb(12));
    check("as_result", 32'(result), 32'(r & 'hFF));
  endtask

  task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    inbus_x = x;
    inbus_y = y;
    cycle(cb(1));
    cycle(cb(3));
    for (int i = 0; i < W; i++) begin
      if (q_0 && !q_min1)      cycle(cb(4) | cb(5));
      else if (!q_0 && q_min1) cycle(cb(4));
      cycle(cb(8) | cb(7));
    end
    check("mul_cnt_wrap", 32'(cnt7), 32'd0);
    cycle(cb(13));
    check("mul_result", 32'(result), 32'(p & 'hFFFF));
  endtask

  task automatic do_div(input logic [W-1:0] x, input logic [W-1:0] y);
    int ux, uy;
    ux = int'(x);
    uy = int'(y);
    inbus_x = x;
    inbus_y = y;
    cycle(cb(2));
    cycle(cb(3));
    for (int i = 0; i < W; i++) begin
      cycle(cb(9));
      if (sign) cycle(cb(4));
      else      cycle(cb(4) | cb(5));
      cycle(cb(6) | cb(10));
    end
    if (sign) cycle(cb(11));
    cycle(cb(12));
    cycle(cb(14));
    check("div_result", 32'(result), 32'((((ux / uy) & 'hFF) << 8) | (ux % uy)));
  endtask

  initial begin
    logic [15:0] held;
    rst     = 1'b1;
    c       = '0;
    inbus_x = '0;
    inbus_y = '0;
    @(negedge clk);
    cycle('0);
    cycle('0);
    rst = 1'b0;
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf",    32'(overflow), 32'd0);
    check("rst_status", {28'd0, q_0, q_min1, sign, cnt7}, 32'd0);

    // Directed add/sub cases
    do_addsub(8'h25, 8'h1A, 1'b0, 1'b1);   // 0x003F
    do_addsub(8'h10, 8'h20, 1'b1, 1'b1);   // 0x00F0, sign=1
    do_addsub(8'h7F, 8'h01, 1'b0, 1'b1);   // 0x0080, overflow=1
    do_addsub(8'h80, 8'h01, 1'b1, 1'b1);   // -128-1 overflows

    // Result holds while no control bit is high
    held = 16'h0000 | 16'((-128 - 1) & 'hFF);
    repeat (3) cycle('0);
    check("hold_result", 32'(result), 32'(held));

    // First Booth step by hand: 0 - 2 then arithmetic right shift
    inbus_x = 8'h03;
    inbus_y = 8'h02;
    cycle(cb(1));
    cycle(cb(3));
    cycle(cb(4) | cb(5));
    check("booth_sub_sign", 32'(sign), 32'd1);
    cycle(cb(8));
    check("booth_shift_sign", 32'(sign), 32'd1);
    check("booth_shift_q0",   32'(q_0), 32'd1);
    check("booth_shift_qm1",  32'(q_min1), 32'd1);
    cycle(cb(13));
    check("booth_shift_aq", 32'(result), 32'h0000_FF01);

    // Counter wrap: cnt7 high after the 7th pulse only
    cycle(cb(0));
    for (int i = 0; i < 8; i++) begin
      cycle(cb(10));
      check("cnt7_pulse", 32'(cnt7), 32'(i == 6));
    end

    // Full multiply / divide flows
    do_mul(8'h03, 8'h02);
    do_mul(8'hFD, 8'h02);
    do_mul(8'h80, 8'h80);
    do_div(8'h07, 8'h02);
    do_div(8'hFF, 8'h01);

    // Multi-hot result priority: c13 beats c12
    inbus_x = 8'h12;
    inbus_y = 8'h34;
    cycle(cb(0));
    cycle(cb(3));
    cycle(cb(4));
    cycle(cb(12) | cb(13));
    check("prio_result", 32'(result), 32'h0000_4600);

    // Reset mid-multiply
    inbus_x = 8'h55;
    inbus_y = 8'h7B;
    cycle(cb(1));
    cycle(cb(3));
    cycle(cb(4) | cb(5));
    cycle(cb(8) | cb(7));
    rst = 1'b1;
    cycle('0);
    rst = 1'b0;
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_ovf",    32'(overflow), 32'd0);
    check("midrst_status", {28'd0, q_0, q_min1, sign, cnt7}, 32'd0);
    cycle(cb(13));
    check("midrst_aq", 32'(result), 32'd0);
    cycle(cb(4));
    cycle(cb(12));
    check("midrst_m_zero", 32'(result), 32'd0);

    // Randomized operations against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] rx, ry;
      int op;
      op = int'($urandom_range(0, 3));
      rx = W'($urandom);
      ry = W'($urandom);
      case (op)
        0: do_addsub(rx, ry, 1'b0, 1'b1);
        1: do_addsub(rx, ry, 1'b1, 1'b1);
        2: do_mul(rx, ry);
        default: do_div(rx, W'($urandom_range(1, 127)));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
